// File: rtl/state_pkg.sv
// Shared state encoding for the job FSM: the sequencer, the state register owner
// and any downstream decode logic all import these codes.
package state_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE    = 4'h0;
    localparam logic [STATE_W-1:0] ST_LOAD    = 4'h1;
    localparam logic [STATE_W-1:0] ST_COMPUTE = 4'h2;
    localparam logic [STATE_W-1:0] ST_STORE   = 4'h3;
    localparam logic [STATE_W-1:0] ST_DONE    = 4'h4;
    localparam logic [STATE_W-1:0] ST_ERROR   = 4'hF;

    // Busy covers every state that belongs to an active job.
    function automatic logic is_busy(input logic [STATE_W-1:0] s);
        return (s == ST_LOAD) || (s == ST_COMPUTE) || (s == ST_STORE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: counts cycles spent in the current state and restarts
// from zero whenever the state is about to change.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset
    // sampled only on the clock edge, so reset never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/state_sequencer.sv
// Next-state controller for the job FSM: computes next_state from the fed-back
// current_state, handshakes and dwell/pending registers, and decodes Moore strobes.
module state_sequencer
    import state_pkg::*;
#(
    parameter int COMPUTE_CYCLES = 8,
    parameter int TIMEOUT        = 255,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] current_state,
    input  logic               start,
    input  logic               load_ack,
    input  logic               store_ack,
    input  logic               clear,
    output logic [STATE_W-1:0] next_state,
    output logic               load_en,
    output logic               compute_en,
    output logic               store_en,
    output logic               done,
    output logic               error,
    output logic               busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(COMPUTE_CYCLES - 1);

    logic [CNT_W-1:0] w_cnt;
    logic             w_state_change;
    logic             w_job_entry;
    logic             r_pending;

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_state_change),
        .o_count (w_cnt)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = ST_IDLE;
        if (!reset && !clear) begin
            unique case (current_state)
                ST_IDLE:    next_state = (start || r_pending) ? ST_LOAD : ST_IDLE;
                ST_LOAD:    next_state = load_ack ? ST_COMPUTE :
                                         (w_cnt == TIMEOUT_LAST) ? ST_ERROR : ST_LOAD;
                ST_COMPUTE: next_state = (w_cnt == COMPUTE_LAST) ? ST_STORE : ST_COMPUTE;
                ST_STORE:   next_state = store_ack ? ST_DONE :
                                         (w_cnt == TIMEOUT_LAST) ? ST_ERROR : ST_STORE;
                ST_DONE:    next_state = (start || r_pending) ? ST_LOAD : ST_IDLE;
                ST_ERROR:   next_state = ST_ERROR;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    assign w_state_change = (next_state != current_state);
    assign w_job_entry    = ((current_state == ST_IDLE) || (current_state == ST_DONE)) &&
                            (next_state == ST_LOAD);

    // One-deep job queue: a start seen mid-job is remembered, further ones are dropped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pending <= 1'b0;
        end else if (w_job_entry) begin
            r_pending <= 1'b0;
        end else if (start && ((current_state == ST_LOAD) ||
                               (current_state == ST_COMPUTE) ||
                               (current_state == ST_STORE))) begin
            r_pending <= 1'b1;
        end
    end

    always_comb begin
        load_en    = (current_state == ST_LOAD);
        compute_en = (current_state == ST_COMPUTE);
        store_en   = (current_state == ST_STORE);
        done       = (current_state == ST_DONE);
        error      = (current_state == ST_ERROR);
        busy       = is_busy(current_state);
    end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: closes the state-register loop locally and
// compares each cycle's state and strobes against a queue of expected states.
module tb_state_sequencer;
    import state_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                load_ack = 1'b0;
    logic                store_ack = 1'b0;
    logic                clear = 1'b0;
    logic                force_en = 1'b0;
    logic [STATE_W-1:0]  force_val = '0;
    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  current_state;
    logic [STATE_W-1:0]  next_state;
    logic                load_en, compute_en, store_en, done, error, busy;
    logic                reset_n;

    int n_checks = 0;
    int n_errors = 0;
    logic [STATE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    assign reset_n       = ~reset;
    assign current_state = force_en ? force_val : r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= next_state;
    end

    state_sequencer #(.COMPUTE_CYCLES(8), .TIMEOUT(5), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .current_state (current_state),
        .start         (start),
        .load_ack      (load_ack),
        .store_ack     (store_ack),
        .clear         (clear),
        .next_state    (next_state),
        .load_en       (load_en),
        .compute_en    (compute_en),
        .store_en      (store_en),
        .done          (done),
        .error         (error),
        .busy          (busy)
    );

    function automatic logic [7:0] exp_outs(input logic [STATE_W-1:0] s);
        logic [5:0] o;
        o = 6'b0;
        case (s)
            ST_LOAD:    o = 6'b100001;
            ST_COMPUTE: o = 6'b010001;
            ST_STORE:   o = 6'b001001;
            ST_DONE:    o = 6'b000101;
            ST_ERROR:   o = 6'b000010;
            default:    o = 6'b000000;
        endcase
        return {2'b00, o};
    endfunction

    function automatic logic [7:0] obs_outs();
        return {2'b00, load_en, compute_en, store_en, done, error, busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the state expected after the edge, then compare.
    task automatic step(input logic s, input logic la, input logic sa, input logic cl,
                        input logic [STATE_W-1:0] exp_state, input string tag);
        logic [STATE_W-1:0] e;
        start = s; load_ack = la; store_ack = sa; clear = cl;
        exp_q.push_back(exp_state);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; load_ack = 1'b0; store_ack = 1'b0; clear = 1'b0;
        e = exp_q.pop_front();
        check({tag, " state"}, {4'h0, r_state}, {4'h0, e});
        check({tag, " outs"}, obs_outs(), exp_outs(e));
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, ST_IDLE, tag);
    endtask

    task automatic compute_run(input string tag);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, ST_COMPUTE, tag);
        step(0, 0, 0, 0, ST_STORE, tag);
    endtask

    initial begin
        // Reset: next_state forced to 0 even with start requested.
        @(negedge clk);
        start = 1'b1;
        #1;
        check("reset next_state", {4'h0, next_state}, 8'h00);
        check("reset outs", obs_outs(), 8'h00);
        start = 1'b0;
        step(0, 0, 0, 0, ST_IDLE, "reset hold");
        reset = 1'b0;
        idle_steps(10, "idle");

        // Nominal job with immediate acks.
        step(1, 0, 0, 0, ST_LOAD, "nom start");
        step(0, 1, 0, 0, ST_COMPUTE, "nom load_ack");
        compute_run("nom compute");
        step(0, 0, 1, 0, ST_DONE, "nom store_ack");
        step(0, 0, 0, 0, ST_IDLE, "nom after done");

        // Load timeout, error hold, clear.
        step(1, 0, 0, 0, ST_LOAD, "to start");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, ST_LOAD, "to wait");
        step(0, 0, 0, 0, ST_ERROR, "to expire");
        step(0, 0, 0, 0, ST_ERROR, "err hold1");
        step(1, 0, 0, 0, ST_ERROR, "err hold2");
        step(0, 0, 0, 1, ST_IDLE, "err clear");
        idle_steps(2, "post clear");

        // Store ack arrives on the final timeout cycle: ack wins.
        step(1, 0, 0, 0, ST_LOAD, "tie start");
        step(0, 1, 0, 0, ST_COMPUTE, "tie load_ack");
        compute_run("tie compute");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, ST_STORE, "tie wait");
        step(0, 0, 1, 0, ST_DONE, "tie ack");
        step(0, 0, 0, 0, ST_IDLE, "tie idle");

        // Queued start: two pulses in COMPUTE, only one extra job.
        step(1, 0, 0, 0, ST_LOAD, "q start");
        step(0, 1, 0, 0, ST_COMPUTE, "q load_ack");
        step(0, 0, 0, 0, ST_COMPUTE, "q c1");
        step(1, 0, 0, 0, ST_COMPUTE, "q pulse1");
        step(0, 0, 0, 0, ST_COMPUTE, "q c3");
        step(1, 0, 0, 0, ST_COMPUTE, "q pulse2");
        step(0, 0, 0, 0, ST_COMPUTE, "q c5");
        step(0, 0, 0, 0, ST_COMPUTE, "q c6");
        step(0, 0, 0, 0, ST_COMPUTE, "q c7");
        step(0, 0, 0, 0, ST_STORE, "q store");
        step(0, 0, 1, 0, ST_DONE, "q done1");
        step(0, 0, 0, 0, ST_LOAD, "q reload");
        step(0, 1, 0, 0, ST_COMPUTE, "q2 load_ack");
        compute_run("q2 compute");
        step(0, 0, 1, 0, ST_DONE, "q2 done");
        idle_steps(4, "q no third");

        // Abort mid-COMPUTE with a queued start: pending must be dropped.
        step(1, 0, 0, 0, ST_LOAD, "ab start");
        step(0, 1, 0, 0, ST_COMPUTE, "ab load_ack");
        step(1, 0, 0, 0, ST_COMPUTE, "ab queue");
        step(0, 0, 0, 1, ST_IDLE, "ab clear");
        idle_steps(3, "ab pending gone");

        // Illegal state code decodes to IDLE and no strobes.
        force_en = 1'b1;
        force_val = 4'h9;
        start = 1'b1;
        #1;
        check("illegal next_state", {4'h0, next_state}, 8'h00);
        check("illegal outs", obs_outs(), 8'h00);
        force_en = 1'b0;
        start = 1'b0;
        #1;

        // Reset mid-job discards the queued job.
        step(1, 0, 0, 0, ST_LOAD, "rst start");
        step(0, 1, 0, 0, ST_COMPUTE, "rst load_ack");
        step(1, 0, 0, 0, ST_COMPUTE, "rst queue");
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 0, ST_IDLE, "rst assert");
        reset = 1'b0;
        idle_steps(3, "rst no job");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
